seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Multi-cycle restoring divider: the subtract/inverse counterpart to the datapath adder in the component library.
- Computes QUOT = A / B and REM = A % B using one shift-and-subtract step per clock.
- Uses a START/DONE handshake and is sized by DATAWIDTH like the other datapath components.
- Intended for scheduled datapaths where a combinational divider would be too slow.

Parameters:
DATAWIDTH, 64, operand/result width in bits (≥2)

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous, active-low reset (0 = reset)
START  input  1  request; sampled only in IDLE
A  input  DATAWIDTH  dividend; captured when START accepted
B  input  DATAWIDTH  divisor; captured when START accepted
BUSY  output  1  high while in CALC or FIN
DONE  output  1  one-cycle pulse, results valid
QUOT  output  DATAWIDTH  quotient, registered
REM  output  DATAWIDTH  remainder, registered
DIVZ  output  1  divide-by-zero flag for the last operation

Behaviour:
- Reset (Rst=0, any time, asynchronous):
  - state=IDLE; BUSY=0, DONE=0, QUOT=0, REM=0, DIVZ=0.
  - An in-flight operation is discarded; no DONE follows.
- States: IDLE, CALC, FIN.
- IDLE:
  - START=1 at edge E0: capture A→dividend shift reg, B→divisor reg, clear partial remainder, load counter=DATAWIDTH.
  - If B≠0: go to CALC.
  - If B==0: go directly to FIN with DIVZ=1, QUOT=all ones, REM=A.
  - START=0: stay in IDLE; outputs hold their previous values.
- CALC, each edge:
  - Shift {R,Q} left one bit.
  - Trial T=R_shifted−B, computed at DATAWIDTH+1 bits.
  - If T≥0 (no borrow): R=T and Q[0]=1; else keep R and Q[0]=0.
  - Decrement counter.
  - On the edge where counter goes 1→0: load QUOT/REM from Q/R, DIVZ=0, go to FIN.
- FIN: DONE=1 for exactly one cycle; next edge returns to IDLE.
- Latency:
  - Normal: DONE high in the cycle following edge E0+DATAWIDTH.
  - Divide by zero: DONE high in the cycle following E0.
  - Next START can be accepted at edge E0+DATAWIDTH+2 (normal) or E0+2 (div-by-zero).
- START while BUSY=1: ignored, not queued; A/B changes while BUSY have no effect.
- QUOT/REM/DIVZ change only on the FIN-entry edge or reset; they hold until the next completion.
- BUSY=1 from the edge after E0 through the FIN cycle inclusive.
- Arithmetic is unsigned, with exact results for all A,B with B≠0:
  - A < B → QUOT=0, REM=A.
  - B=1 → QUOT=A, REM=0.
  - A=0 → QUOT=0, REM=0.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - At E0, capture magnitudes |A| and |B| and record the sign bits.
  - At FIN entry:
    - QUOT negated if sign(A)≠sign(B); truncation toward zero.
    - REM takes the sign of A.
  - Latency unchanged.
  - Overflow case MIN/−1 → QUOT=MIN (wraps), REM=0, DIVZ=0.
  - Divide by zero → QUOT=all ones, REM=A, DIVZ=1.
- Undefined: unsigned-only behaviour as above; no sign logic synthesized.

Test Plan:
- DATAWIDTH=8, A=100, B=7, START 1 cycle → BUSY for 9 cycles; DONE pulse after edge E0+8; QUOT=14, REM=2, DIVZ=0.
- DATAWIDTH=8 corners, back-to-back:
  - 255/1 → QUOT=255, REM=0.
  - 3/200 → QUOT=0, REM=3.
  - 0/9 → QUOT=0, REM=0.
  - Each DONE exactly one cycle; next START accepted at E0+10.
- DATAWIDTH=8, A=5, B=0 → DONE in cycle after E0; DIVZ=1, QUOT=0xFF, REM=5; next valid division clears DIVZ.
- Start of 100/7 followed by START=1 with A=50, B=5 at E0+3:
  - Ignored; single DONE with QUOT=14, REM=2.
  - No second DONE without a new START after IDLE.
- Rst=0 asserted mid-CALC (between edges) → outputs zero immediately, asynchronously; no DONE after release; fresh 100/7 then yields 14/2.
- SEQ_DIV_SIGNED_EN, DATAWIDTH=8:
  - −100/7 → QUOT=0xF2 (−14), REM=0xFE (−2).
  - 100/−7 → QUOT=0xF2, REM=0x02.
  - −128/−1 → QUOT=0x80, REM=0x00.

Source files
------------

// File: rtl/seq_div.sv
// Multi-cycle restoring divider, one shift-and-subtract step per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands.
module seq_div #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 START,
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [DATAWIDTH-1:0] QUOT,
  output logic [DATAWIDTH-1:0] REM,
  output logic                 DIVZ
);

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t         state_q;
  logic [W-1:0]   r_q;
  logic [W-1:0]   q_q;
  logic [W-1:0]   b_q;
  logic [CW-1:0]  cnt_q;

  logic [W:0]     sh;
  logic [W+1:0]   diff;
  logic [W-1:0]   r_d;
  logic [W-1:0]   q_d;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W-1:0]   quot_f;
  logic [W-1:0]   rem_f;

`ifdef SEQ_DIV_SIGNED_EN
  logic sa_q;
  logic sb_q;

  assign a_mag  = A[W-1] ? -A : A;
  assign b_mag  = B[W-1] ? -B : B;
  assign quot_f = (sa_q ^ sb_q) ? -q_d : q_d;
  assign rem_f  = sa_q ? -r_d : r_d;
`else
  assign a_mag  = A;
  assign b_mag  = B;
  assign quot_f = q_d;
  assign rem_f  = r_d;
`endif

  // Partial remainder stays below the divisor, so W+2 bits hold the borrow
  always_comb begin
    sh   = {r_q, q_q[W-1]};
    diff = {1'b0, sh} - {2'b00, b_q};
    r_d  = sh[W-1:0];
    q_d  = {q_q[W-2:0], 1'b0};
    if (!diff[W+1]) begin
      r_d = diff[W-1:0];
      q_d = {q_q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      QUOT    <= '0;
      REM     <= '0;
      DIVZ    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            q_q   <= a_mag;
            b_q   <= b_mag;
            r_q   <= '0;
            cnt_q <= CW'(W);
            BUSY  <= 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
            sa_q  <= A[W-1];
            sb_q  <= B[W-1];
`endif
            if (B == '0) begin
              QUOT    <= '1;
              REM     <= A;
              DIVZ    <= 1'b1;
              DONE    <= 1'b1;
              state_q <= FIN;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            QUOT    <= quot_f;
            REM     <= rem_f;
            DIVZ    <= 1'b0;
            DONE    <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div at DATAWIDTH=8.
// Signed vectors run only when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] QUOT;
  logic [W-1:0] REM;
  logic         DIVZ;

  int checks = 0;
  int errors = 0;

  seq_div #(.DATAWIDTH(W)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .START(START),
    .A    (A),
    .B    (B),
    .BUSY (BUSY),
    .DONE (DONE),
    .QUOT (QUOT),
    .REM  (REM),
    .DIVZ (DIVZ)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the DONE cycle.
  task automatic run(input string tag,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] eq,
                     input logic [W-1:0] er,
                     input logic ez,
                     input int lat);
    int n;
    int bc;
    START = 1'b1;
    A = a;
    B = b;
    @(posedge Clk);
    #1;
    START = 1'b0;
    A = 8'h5A;
    B = 8'h03;
    n = 0;
    bc = 0;
    while (n < 40) begin
      @(negedge Clk);
      n++;
      if (BUSY) bc++;
      if (DONE) break;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, bc, lat);
    chk({tag, "_quot"}, QUOT, eq);
    chk({tag, "_rem"}, REM, er);
    chk({tag, "_divz"}, DIVZ, ez);
    @(negedge Clk);
    chk({tag, "_done1"}, DONE, 1'b0);
    chk({tag, "_idle"}, BUSY, 1'b0);
  endtask

  initial begin
    int n;
    int dc;

    repeat (2) @(negedge Clk);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_quot", QUOT, 8'h00);
    chk("rst_rem", REM, 8'h00);
    chk("rst_divz", DIVZ, 1'b0);
    Rst = 1'b1;
    @(negedge Clk);

    run("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    run("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run("d3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 9);
    run("d0_9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 9);
    run("dz5", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1);
    run("d17_5", 8'd17, 8'd5, 8'd3, 8'd2, 1'b0, 9);

    // START while busy must be ignored
    START = 1'b1;
    A = 8'd100;
    B = 8'd7;
    @(posedge Clk);
    #1;
    START = 1'b0;
    n = 0;
    dc = 0;
    repeat (2) begin
      @(negedge Clk);
      n++;
    end
    START = 1'b1;
    A = 8'd50;
    B = 8'd5;
    @(posedge Clk);
    #1;
    START = 1'b0;
    A = 8'd0;
    B = 8'd0;
    while (n < 40) begin
      @(negedge Clk);
      n++;
      if (DONE) break;
    end
    chk("ign_lat", n, 9);
    chk("ign_quot", QUOT, 8'd14);
    chk("ign_rem", REM, 8'd2);
    repeat (20) begin
      @(negedge Clk);
      if (DONE) dc++;
    end
    chk("ign_nodone", dc, 0);

    // asynchronous reset mid-calculation
    START = 1'b1;
    A = 8'd100;
    B = 8'd7;
    @(posedge Clk);
    #1;
    START = 1'b0;
    repeat (3) @(negedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    chk("arst_busy", BUSY, 1'b0);
    chk("arst_quot", QUOT, 8'h00);
    chk("arst_rem", REM, 8'h00);
    chk("arst_divz", DIVZ, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    dc = 0;
    repeat (20) begin
      @(negedge Clk);
      if (DONE) dc++;
    end
    chk("arst_nodone", dc, 0);
    run("post_rst", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);

`ifdef SEQ_DIV_SIGNED_EN
    run("s_m100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 9);
    run("s_100_m7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 9);
    run("s_min_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    run("s_dz", 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
